// File: rtl/rr_burst_arbiter_pkg.sv
// Shared definitions for the round-robin burst arbiter: FSM state encoding
// and default sizing constants.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ   = 3;
  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/rr_burst_arbiter_pick.sv
// Rotate-priority encoder: returns the first set request bit found searching
// upward from ptr with wrap-around.
module rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with bounded burst ownership; the owner keeps the grant
// while requesting, for at most MAX_BURST cycles, then ownership rotates.
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ,
  parameter int MAX_BURST = ARB_MAX_BURST,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy,
  output logic [CNT_W-1:0]   burst_cnt
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t      state;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] next_ptr;
  logic [ID_W-1:0] pick_ptr;
  logic [ID_W-1:0] pick_idx;
  logic            pick_valid;
  logic            release_now;

  // The single encoder serves both the idle search and the release hand-off.
  assign next_ptr    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
  assign pick_ptr    = (state == ARB_GRANT) ? next_ptr : ptr;
  assign release_now = !req[gnt_id] || (burst_cnt == CNT_W'(MAX_BURST));

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_valid) begin
            state     <= ARB_GRANT;
            gnt       <= ONE << pick_idx;
            gnt_id    <= pick_idx;
            busy      <= 1'b1;
            burst_cnt <= CNT_W'(1);
          end
        end
        ARB_GRANT: begin
          if (!release_now) begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end else begin
            ptr <= next_ptr;
            if (pick_valid) begin
              gnt       <= ONE << pick_idx;
              gnt_id    <= pick_idx;
              burst_cnt <= CNT_W'(1);
            end else begin
              state     <= ARB_IDLE;
              gnt       <= '0;
              gnt_id    <= '0;
              busy      <= 1'b0;
              burst_cnt <= '0;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  a_req_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(req));
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
Round-robin arbiter with bounded burst ownership for a shared resource with NUM_REQ requesters.
- Extends the existing 3-requester fixed arbiter: a requester keeps the grant while it holds req, up to MAX_BURST cycles, then ownership rotates.
- Sits between the requesting agents and the shared resource's select logic.
- All outputs are registered.

Parameters:
NUM_REQ, 3, number of requesters (2..8).
MAX_BURST, 4, maximum consecutive grant cycles per ownership (1..15).
ID_W, $clog2(NUM_REQ), width of gnt_id.
CNT_W, $clog2(MAX_BURST+1), width of burst_cnt.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  reset, asynchronous, active-low; asserted (0) clears all state immediately; deassertion is synchronous to clk externally.
req  input  NUM_REQ  per-requester request level; bit i = requester i.
gnt  output  NUM_REQ  one-hot or zero grant vector.
gnt_id  output  ID_W  index of current owner; 0 when idle.
busy  output  1  1 while any gnt bit is high.
burst_cnt  output  CNT_W  cycles granted in current burst, including the current cycle; 0 when idle.

Behaviour:
- Reset (rst=0): gnt=0, gnt_id=0, busy=0, burst_cnt=0, state=IDLE, rr pointer ptr=0. Applies mid-burst too: the grant drops asynchronously. The first grant after reset again starts searching from requester 0.
- Arbitration function pick(ptr, req): first set bit of req searching ptr, ptr+1, ..., NUM_REQ-1, 0, ..., ptr-1 (wrap-around).
- States: IDLE, GRANT.
- IDLE, at posedge:
  - If req==0: stay in IDLE.
  - Else: k=pick(ptr,req); gnt<=1<<k, gnt_id<=k, burst_cnt<=1, busy<=1, go to GRANT.
  - Latency: req sampled high at edge N gives gnt high after edge N (1 cycle).
- GRANT with owner k, at posedge: release = (req[k]==0) || (burst_cnt==MAX_BURST).
  - No release: burst_cnt<=burst_cnt+1; owner unchanged.
  - Release: ptr<=(k+1) mod NUM_REQ, then w=pick((k+1) mod NUM_REQ, req) using the same-edge req.
    - req==0: go to IDLE; gnt, gnt_id, burst_cnt, busy <=0.
    - Otherwise grant w back-to-back, with no idle cycle; burst_cnt<=1.
- Burst expiry with req[k] still high: k has lowest priority. If k is the only requester it is re-granted immediately; gnt stays high and burst_cnt restarts at 1.
- A requester dropping req mid-burst releases at the edge where the low is sampled. gnt may stay high one cycle after req falls.
- Requests from non-owners never pre-empt the owner.
- gnt is never multi-hot. X on req is not permitted while rst=1; the assertion checker flags it.
- MAX_BURST=1: every cycle is a re-arbitration, giving pure round-robin.

Decomposition:
- Package arb_pkg holds the state enum (ARB_IDLE, ARB_GRANT) and the default constants ARB_NUM_REQ=3 and ARB_MAX_BURST=4.
- One sub-module, rr_pick: combinational rotate-priority encoder with inputs req and ptr, outputs valid and idx. It is instantiated once and used for both the IDLE and the release decision.
- Top module holds the FSM, counter and pointer.

Test Plan:
- Reset/idle: rst=0 for 5 cycles, then rst=1 with req=000 → gnt=000, gnt_id=0, busy=0, burst_cnt=0 every cycle.
- Single short request: req0 high for 2 sampled edges, then low → gnt=001 for exactly 2 cycles starting 1 cycle after req0 is sampled; burst_cnt=1,2; then gnt=000.
- Burst expiry, sole requester: req0 held for 10 cycles (MAX_BURST=4) → gnt=001 continuous; burst_cnt sequence 1,2,3,4,1,2,3,4,1,2. gnt drops 1 cycle after req0 falls.
- Rotation: req=011 held → gnt 001 ×4, 010 ×4, 001 ×4 with no gap cycles.
- Full contention: req=111 held → gnt_id 0,1,2,0 each for 4 cycles. Then drop req1 during requester 0's burst → next owner is 2, then 0.
- Reset mid-burst: req=110, assert rst=0 while gnt=010 with burst_cnt=2 → gnt=000 immediately, without waiting for a clock edge. After release the first grant is requester 1 (ptr=0 searches 0, 1) and burst_cnt=1.
